// File: rtl/var_access_unit.sv
// var_access_unit
//   Decodes a variable number into a frame-pointer relative (local) or
//   global-pointer relative (global) byte address. It then reads or writes
//   one full DATA_W-bit word over a byte-wide memory port. Words are stored
//   big-endian: the most significant byte is at the lowest address.
//   The unit takes one request at a time.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   FP, GP        frame / global pointer, sampled when a request is accepted
//   req_valid     request present
//   req_ready     unit idle and able to accept
//   req_write     1 = write, 0 = read
//   req_var       variable number
//   req_wdata     write word
//   rsp_valid     one-cycle response pulse
//   rsp_data      read word (0 for writes and errors), held between pulses
//   rsp_err       illegal variable number, qualified by rsp_valid
//   mem_addr      byte address (holds its value between strobes)
//   mem_rd        read strobe; the byte returns on mem_rdata one cycle later
//   mem_wr        write strobe
//   mem_wdata     write byte (holds its value between strobes)
//   mem_rdata     read byte
module var_access_unit #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int N_LOCALS    = 15,
   parameter int GLOBAL_BASE = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] FP,
   input  logic [ADDR_W-1:0] GP,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [7:0]        req_var,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   localparam int                WB        = DATA_W / 8;
   localparam int                CW        = (WB > 1) ? $clog2(WB) : 1;
   localparam logic [CW-1:0]     LAST_BYTE = CW'(WB - 1);
   localparam logic [7:0]        NL_V      = 8'(N_LOCALS);
   localparam logic [7:0]        GB_V      = 8'(GLOBAL_BASE);
   localparam logic [ADDR_W-1:0] WB_A      = ADDR_W'(WB);

   typedef enum logic [1:0] {
      IDLE,
      ERR,
      ACCESS,
      RLAST
   } state_e;

   state_e            state_q;
   logic              write_q;
   logic [CW-1:0]     cnt_q;
   logic [DATA_W-1:0] wbuf_q;
   logic [DATA_W-1:0] rbuf_q;

   logic              ready_q;
   logic              rsp_valid_q;
   logic              rsp_err_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              mem_rd_q;
   logic              mem_wr_q;
   logic [7:0]        mem_wdata_q;

   // Decode of the request as currently presented
   logic              legal_d;
   logic [ADDR_W-1:0] base_d;
   // Read buffer with the byte on mem_rdata appended as the least significant byte
   logic [DATA_W-1:0] rbuf_d;
   logic [CW-1:0]     cnt_d;

   always_comb begin
      legal_d = 1'b0;
      base_d  = '0;
      if ((req_var != 8'd0) && (req_var <= NL_V)) begin
         legal_d = 1'b1;
         base_d  = FP + WB_A * ADDR_W'(req_var - 8'd1);
      end else if (req_var >= GB_V) begin
         legal_d = 1'b1;
         base_d  = GP + WB_A * ADDR_W'(req_var - GB_V);
      end
   end

   always_comb begin
      rbuf_d = (rbuf_q << 8) | DATA_W'(mem_rdata);
      cnt_d  = cnt_q + 1'b1;
   end

   // Only the decoded start address is kept at accept. Every later byte
   // address is derived from it, so FP/GP changes after accept have no effect.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         write_q     <= 1'b0;
         cnt_q       <= '0;
         wbuf_q      <= '0;
         rbuf_q      <= '0;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= '0;
         mem_addr_q  <= '0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_wdata_q <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;

         case (state_q)
            IDLE: begin
               if (req_valid && ready_q) begin
                  ready_q <= 1'b0;
                  write_q <= req_write;
                  if (!legal_d) begin
                     state_q     <= ERR;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_data_q  <= '0;
                  end else begin
                     state_q    <= ACCESS;
                     cnt_q      <= '0;
                     mem_addr_q <= base_d;
                     mem_rd_q   <= ~req_write;
                     mem_wr_q   <= req_write;
                     wbuf_q     <= req_wdata << 8;
                     if (req_write) begin
                        mem_wdata_q <= req_wdata[DATA_W-1 -: 8];
                        // A single-byte write responds in its only byte cycle
                        if (WB == 1) begin
                           rsp_valid_q <= 1'b1;
                           rsp_data_q  <= '0;
                        end
                     end
                  end
               end
            end

            ERR: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
            end

            ACCESS: begin
               // Read data lags its strobe by one cycle: the byte for strobe
               // cnt_q-1 is on mem_rdata now.
               if (!write_q && (cnt_q != '0)) begin
                  rbuf_q <= rbuf_d;
               end
               if (cnt_q == LAST_BYTE) begin
                  mem_rd_q <= 1'b0;
                  mem_wr_q <= 1'b0;
                  if (write_q) begin
                     state_q <= IDLE;
                     ready_q <= 1'b1;
                  end else begin
                     state_q <= RLAST;
                  end
               end else begin
                  cnt_q      <= cnt_d;
                  mem_addr_q <= mem_addr_q + 1'b1;
                  if (write_q) begin
                     mem_wdata_q <= wbuf_q[DATA_W-1 -: 8];
                     wbuf_q      <= wbuf_q << 8;
                     // The response rides on the final write byte cycle
                     if (cnt_d == LAST_BYTE) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                     end
                  end
               end
            end

            RLAST: begin
               // First cycle captures the final byte and raises the response;
               // the second cycle (response visible) returns to IDLE so that
               // req_ready rises only after the pulse.
               if (!rsp_valid_q) begin
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= rbuf_d;
                  rbuf_q      <= rbuf_d;
               end else begin
                  state_q <= IDLE;
                  ready_q <= 1'b1;
               end
            end

            default: begin
               state_q  <= IDLE;
               ready_q  <= 1'b1;
               mem_rd_q <= 1'b0;
               mem_wr_q <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign mem_addr  = mem_addr_q;
   assign mem_rd    = mem_rd_q;
   assign mem_wr    = mem_wr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_var_access_unit.sv
// Self-checking bench for var_access_unit.
// Main instance: default parameters (16-bit words, 15 locals, globals from 16).
// Second instance: 32-bit words with 14 locals, used for the wide write, the
// illegal-gap number and the mid-access reset.
module tb_var_access_unit;

   localparam int LOGN = 16384;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   // ---------------- main DUT ----------------
   logic        rst;
   logic [15:0] FP, GP;
   logic        req_valid, req_ready, req_write;
   logic [7:0]  req_var;
   logic [15:0] req_wdata;
   logic        rsp_valid, rsp_err;
   logic [15:0] rsp_data;
   logic [15:0] mem_addr;
   logic        mem_rd, mem_wr;
   logic [7:0]  mem_wdata, mem_rdata;

   var_access_unit #(.ADDR_W(16), .DATA_W(16), .N_LOCALS(15), .GLOBAL_BASE(16)) u_dut (
      .clk(clk), .rst(rst), .FP(FP), .GP(GP),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_var(req_var), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // ---------------- 32-bit DUT ----------------
   logic        rst2;
   logic [15:0] FP2, GP2;
   logic        req_valid2, req_ready2, req_write2;
   logic [7:0]  req_var2;
   logic [31:0] req_wdata2;
   logic        rsp_valid2, rsp_err2;
   logic [31:0] rsp_data2;
   logic [15:0] mem_addr2;
   logic        mem_rd2, mem_wr2;
   logic [7:0]  mem_wdata2;
   logic [7:0]  mem_rdata2 = 8'h00;

   var_access_unit #(.ADDR_W(16), .DATA_W(32), .N_LOCALS(14), .GLOBAL_BASE(16)) u_dut32 (
      .clk(clk), .rst(rst2), .FP(FP2), .GP(GP2),
      .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write2),
      .req_var(req_var2), .req_wdata(req_wdata2),
      .rsp_valid(rsp_valid2), .rsp_data(rsp_data2), .rsp_err(rsp_err2),
      .mem_addr(mem_addr2), .mem_rd(mem_rd2), .mem_wr(mem_wr2),
      .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2)
   );

   // ---------------- memory: phys serves the DUT, ref is the model's copy ----------------
   logic [7:0] phys_mem [0:65535];
   logic [7:0] ref_mem  [0:65535];

   always @(posedge clk) begin
      if (mem_rd) mem_rdata <= phys_mem[mem_addr];
      if (mem_wr) phys_mem[mem_addr] = mem_wdata;
   end

   // ---------------- observation ----------------
   typedef struct { int cyc; logic [15:0] addr; logic [1:0] kind; logic [7:0] data; } strb_t;
   typedef struct { int cyc; logic [15:0] data; logic err; } rsp_t;

   strb_t obs_strb[$], exp_strb[$];
   rsp_t  obs_rsp[$],  exp_rsp[$];
   bit    ready_log [0:LOGN-1];
   bit    busy_exp  [0:LOGN-1];
   int    chk_from = 0;

   always @(negedge clk) begin
      strb_t s;
      rsp_t  r;
      if (mem_rd || mem_wr) begin
         s.cyc = cyc; s.addr = mem_addr; s.kind = {mem_rd, mem_wr};
         s.data = mem_wr ? mem_wdata : 8'h00;
         obs_strb.push_back(s);
      end
      if (rsp_valid) begin
         r.cyc = cyc; r.data = rsp_data; r.err = rsp_err;
         obs_rsp.push_back(r);
      end
      if (cyc < LOGN) ready_log[cyc] = req_ready;
   end

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] pk_strb(input strb_t s);
      return {32'(s.cyc), s.addr, 6'b0, s.kind, s.data};
   endfunction

   function automatic logic [63:0] pk_rsp(input rsp_t r);
      return {32'(r.cyc), 15'b0, r.err, r.data};
   endfunction

   task automatic push_strb(input int c, input logic [15:0] a, input logic w, input logic [7:0] d);
      strb_t s;
      s.cyc = c; s.addr = a; s.kind = w ? 2'b01 : 2'b10; s.data = w ? d : 8'h00;
      exp_strb.push_back(s);
   endtask

   task automatic push_rsp(input int c, input logic [15:0] d, input logic e);
      rsp_t r;
      r.cyc = c; r.data = d; r.err = e;
      exp_rsp.push_back(r);
   endtask

   task automatic set_busy(input int a, input int b);
      for (int c = a; c <= b; c++) if (c < LOGN) busy_exp[c] = 1'b1;
   endtask

   task automatic verify(input int upto);
      int nr;
      nr = 0;
      chk("strobe_count", 64'(obs_strb.size()), 64'(exp_strb.size()));
      for (int i = 0; i < exp_strb.size() && i < obs_strb.size(); i++)
         chk("strobe", pk_strb(obs_strb[i]), pk_strb(exp_strb[i]));
      chk("rsp_count", 64'(obs_rsp.size()), 64'(exp_rsp.size()));
      for (int i = 0; i < exp_rsp.size() && i < obs_rsp.size(); i++)
         chk("response", pk_rsp(obs_rsp[i]), pk_rsp(exp_rsp[i]));
      for (int c = chk_from; c < upto && c < LOGN; c++)
         if (ready_log[c] != !busy_exp[c]) nr++;
      chk("req_ready_pattern", 64'(nr), 64'(0));
      obs_strb.delete(); exp_strb.delete(); obs_rsp.delete(); exp_rsp.delete();
      chk_from = upto;
   endtask

   // Reference model: word-level decode and access from the addressing rules.
   task automatic expect_txn(input int t, input int v, input logic w, input logic [15:0] wd,
                             input logic [15:0] fp, input logic [15:0] gp, output int lat);
      int base, addr;
      logic [15:0] data;
      logic [7:0]  b;
      if (v >= 1 && v <= 15)  base = (int'(fp) + 2 * (v - 1)) % 65536;
      else if (v >= 16)       base = (int'(gp) + 2 * (v - 16)) % 65536;
      else                    base = -1;
      if (base < 0) begin
         lat = 1;
         push_rsp(t + 1, 16'h0000, 1'b1);
      end else begin
         data = 16'h0000;
         for (int i = 0; i < 2; i++) begin
            addr = (base + i) % 65536;
            if (w) begin
               b = (i == 0) ? wd[15:8] : wd[7:0];
               ref_mem[addr] = b;
            end else begin
               b = ref_mem[addr];
               data = {data[7:0], b};
            end
            push_strb(t + 1 + i, 16'(addr), w, b);
         end
         lat = w ? 2 : 4;
         push_rsp(t + lat, w ? 16'h0000 : data, 1'b0);
      end
      set_busy(t + 1, t + lat);
   endtask

   // Present one request in an idle cycle; it is accepted at the edge closing
   // cycle t. Inputs are scrambled afterwards to show they are not re-sampled.
   task automatic issue(input logic [7:0] v, input logic w, input logic [15:0] wd,
                        input logic [15:0] fp, input logic [15:0] gp, output int t);
      @(negedge clk);
      req_var = v; req_write = w; req_wdata = wd; FP = fp; GP = gp; req_valid = 1'b1;
      t = cyc;
      @(negedge clk);
      req_valid = 1'b0; FP = 16'($urandom); GP = 16'($urandom);
      req_var = 8'($urandom); req_wdata = 16'($urandom);
   endtask

   typedef struct {
      logic [7:0]  v; logic w; logic [15:0] wdata, fp, gp;
      logic [7:0]  d0, d1; logic err; logic [15:0] a0, a1, data;
   } vec_t;

   vec_t tbl [10];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1);
   end

   initial begin
      int t, lat, t0, nq;
      logic [7:0] v;
      logic w;
      logic [15:0] wd, fp, gp;
      logic [7:0] exp32 [4];

      //           v      w     wdata     fp        gp        d0     d1     err   a0        a1        data
      tbl[0] = '{8'h03, 1'b0, 16'h0000, 16'h0100, 16'h0000, 8'hAB, 8'hCD, 1'b0, 16'h0104, 16'h0105, 16'hABCD};
      tbl[1] = '{8'h12, 1'b1, 16'h1234, 16'h0000, 16'h2000, 8'h12, 8'h34, 1'b0, 16'h2004, 16'h2005, 16'h0000};
      tbl[2] = '{8'h00, 1'b0, 16'h0000, 16'h0100, 16'h2000, 8'h00, 8'h00, 1'b1, 16'h0000, 16'h0000, 16'h0000};
      tbl[3] = '{8'h0F, 1'b0, 16'h0000, 16'h0100, 16'h2000, 8'h5A, 8'hA5, 1'b0, 16'h011C, 16'h011D, 16'h5AA5};
      tbl[4] = '{8'h11, 1'b0, 16'h0000, 16'h0100, 16'hFFFE, 8'h11, 8'h22, 1'b0, 16'h0000, 16'h0001, 16'h1122};
      tbl[5] = '{8'h10, 1'b0, 16'h0000, 16'h0100, 16'hFFFF, 8'h33, 8'h44, 1'b0, 16'hFFFF, 16'h0000, 16'h3344};
      tbl[6] = '{8'h01, 1'b1, 16'hBEEF, 16'hFFFF, 16'h0000, 8'hBE, 8'hEF, 1'b0, 16'hFFFF, 16'h0000, 16'h0000};
      tbl[7] = '{8'hFF, 1'b0, 16'h0000, 16'h0000, 16'h1000, 8'h77, 8'h88, 1'b0, 16'h11DE, 16'h11DF, 16'h7788};
      tbl[8] = '{8'h00, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 8'h00, 8'h00, 1'b1, 16'h0000, 16'h0000, 16'h0000};
      tbl[9] = '{8'h0E, 1'b1, 16'hC0DE, 16'h0200, 16'h0000, 8'hC0, 8'hDE, 1'b0, 16'h021A, 16'h021B, 16'h0000};
      exp32 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

      for (int i = 0; i < 65536; i++) begin
         phys_mem[i] = 8'($urandom);
         ref_mem[i]  = phys_mem[i];
      end
      rst = 1'b1; FP = '0; GP = '0; req_valid = 1'b0; req_write = 1'b0; req_var = '0; req_wdata = '0;
      rst2 = 1'b1; FP2 = '0; GP2 = '0; req_valid2 = 1'b0; req_write2 = 1'b0; req_var2 = '0; req_wdata2 = '0;

      repeat (3) @(negedge clk);
      chk("reset_ready", 64'(req_ready), 64'(1));
      chk("reset_rsp", {rsp_valid, rsp_err, rsp_data}, 64'(0));
      chk("reset_mem", {mem_rd, mem_wr, mem_addr, mem_wdata}, 64'(0));
      rst = 1'b0;
      chk_from = cyc;

      // ---- table vectors ----
      for (int k = 0; k < 10; k++) begin
         if (!tbl[k].err && !tbl[k].w) begin
            phys_mem[tbl[k].a0] = tbl[k].d0; ref_mem[tbl[k].a0] = tbl[k].d0;
            phys_mem[tbl[k].a1] = tbl[k].d1; ref_mem[tbl[k].a1] = tbl[k].d1;
         end
         issue(tbl[k].v, tbl[k].w, tbl[k].wdata, tbl[k].fp, tbl[k].gp, t);
         lat = tbl[k].err ? 1 : (tbl[k].w ? 2 : 4);
         if (!tbl[k].err) begin
            push_strb(t + 1, tbl[k].a0, tbl[k].w, tbl[k].d0);
            push_strb(t + 2, tbl[k].a1, tbl[k].w, tbl[k].d1);
            if (tbl[k].w) begin
               ref_mem[tbl[k].a0] = tbl[k].d0;
               ref_mem[tbl[k].a1] = tbl[k].d1;
            end
         end
         push_rsp(t + lat, tbl[k].data, tbl[k].err);
         set_busy(t + 1, t + lat);
         repeat (lat + 1) @(negedge clk);
         verify(cyc);
         chk("rsp_data_hold", 64'(rsp_data), 64'(tbl[k].data));
         chk("rsp_err_idle", 64'(rsp_err), 64'(0));
      end

      // ---- three queued reads with req_valid held high ----
      @(negedge clk);
      req_var = 8'h01; req_write = 1'b0; FP = 16'h0300; GP = 16'h4000; req_valid = 1'b1;
      t0 = cyc;
      @(negedge clk);
      req_var = 8'h02; FP = 16'h7777;
      repeat (5) @(negedge clk);
      req_var = 8'h11; GP = 16'h5000;
      repeat (5) @(negedge clk);
      req_valid = 1'b0;
      expect_txn(t0,      1,  1'b0, 16'h0000, 16'h0300, 16'h4000, lat);
      expect_txn(t0 + 5,  2,  1'b0, 16'h0000, 16'h7777, 16'h4000, lat);
      expect_txn(t0 + 10, 17, 1'b0, 16'h0000, 16'h7777, 16'h5000, lat);
      repeat (5) @(negedge clk);
      verify(cyc);

      // ---- randomized requests against the model ----
      for (int k = 0; k < 120; k++) begin
         case ($urandom_range(0, 9))
            0:          v = 8'h00;
            1, 2, 3, 4: v = 8'($urandom_range(1, 15));
            default:    v = 8'($urandom_range(16, 255));
         endcase
         w  = 1'($urandom_range(0, 1));
         wd = 16'($urandom);
         fp = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFE0, 16'hFFFF)) : 16'($urandom);
         gp = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFE00, 16'hFFFF)) : 16'($urandom);
         issue(v, w, wd, fp, gp, t);
         expect_txn(t, int'(v), w, wd, fp, gp, lat);
         repeat (lat + 1 + int'($urandom_range(0, 2))) @(negedge clk);
         verify(cyc);
      end

      // ---- 32-bit instance: wide write, illegal gap number, reset abort ----
      chk("w32_reset_ready", 64'(req_ready2), 64'(1));
      @(negedge clk);
      rst2 = 1'b0;
      @(negedge clk);
      req_var2 = 8'h02; req_write2 = 1'b1; req_wdata2 = 32'hDEADBEEF; FP2 = 16'h0100; GP2 = 16'h0000;
      req_valid2 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         req_valid2 = 1'b0; FP2 = 16'h0F00;
         chk("w32_strobe", {mem_rd2, mem_wr2, mem_addr2, mem_wdata2}, {2'b01, 16'(16'h0104 + i), exp32[i]});
         chk("w32_rsp", {rsp_valid2, rsp_err2, rsp_data2, req_ready2}, {(i == 3), 1'b0, 32'h0, 1'b0});
      end
      @(negedge clk);
      chk("w32_done", {mem_rd2, mem_wr2, rsp_valid2, req_ready2}, 64'b0001);

      req_var2 = 8'h0F; req_write2 = 1'b0; req_valid2 = 1'b1;
      @(negedge clk);
      req_valid2 = 1'b0;
      chk("w32_illegal", {rsp_valid2, rsp_err2, rsp_data2, mem_rd2, mem_wr2}, {2'b11, 32'h0, 2'b00});
      @(negedge clk);
      chk("w32_illegal_end", {rsp_valid2, rsp_err2, req_ready2, mem_rd2, mem_wr2}, 64'b00100);

      req_var2 = 8'h02; req_write2 = 1'b1; req_wdata2 = 32'h01020304; FP2 = 16'h0100; req_valid2 = 1'b1;
      @(negedge clk);
      req_valid2 = 1'b0;
      chk("abort_t1", {mem_wr2, mem_addr2, mem_wdata2}, {1'b1, 16'h0104, 8'h01});
      @(negedge clk);
      chk("abort_t2", {mem_wr2, mem_addr2, mem_wdata2}, {1'b1, 16'h0105, 8'h02});
      rst2 = 1'b1;
      @(negedge clk);
      rst2 = 1'b0;
      chk("abort_t3", {mem_rd2, mem_wr2, mem_addr2, mem_wdata2, rsp_valid2, req_ready2}, 64'b000_0000_0000_0000_0000_0000_0000_01);
      nq = 0;
      repeat (6) begin
         @(negedge clk);
         if (mem_wr2 || mem_rd2 || rsp_valid2 || !req_ready2) nq++;
      end
      chk("abort_quiet", 64'(nq), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
